// File: rtl/z80_bus_responder.sv
// Z80 bus responder: classifies bus cycles, serves ROM/RAM/IO reads and raises the frame nINT; CONTENTION_EN adds contention outputs.
// Latency: cycle results registered 1 clk_sys after the classifying ce tick; no backpressure, strobes are sampled on ce ticks only.
module z80_bus_responder #(
  parameter int FRAME_LEN = 69888,
  parameter int INT_LEN   = 32
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  input  logic        nRFSH,
  output logic [7:0]  cpu_din,
  output logic        nINT,
  output logic        cyc_valid,
  output logic [2:0]  cyc_type,
  output logic [15:0] cyc_addr,
  output logic        cyc_err,
  output logic [7:0]  port_fe,
  output logic        contended,
  output logic [15:0] cont_cnt
);

  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] INT_THR  = CW'(INT_LEN);

  localparam logic [2:0] CLS_FETCH = 3'd1;
  localparam logic [2:0] CLS_MRD   = 3'd2;
  localparam logic [2:0] CLS_MWR   = 3'd3;
  localparam logic [2:0] CLS_IORD  = 3'd4;
  localparam logic [2:0] CLS_IOWR  = 3'd5;
  localparam logic [2:0] CLS_RFSH  = 3'd6;
  localparam logic [2:0] CLS_INTA  = 3'd7;

  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_WAIT_QUAL, ST_ACTIVE} state_t;

  state_t      state_q, state_d;
  logic        vld_q, err_q;
  logic [2:0]  type_q;
  logic [15:0] addr_q;
  logic [7:0]  din_q, din_d;
  logic [7:0]  fe_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        nint_q;
  logic [7:0]  ram_q [256];

  logic        mreq, iorq, rd, wr, m1, rfsh;
  logic        strobe, bad, tick;
  logic [2:0]  cls;
  logic        classify, err_hit;
  logic        ram_we, port_we;
  logic [7:0]  rd_data;

  assign mreq   = ~nMREQ;
  assign iorq   = ~nIORQ;
  assign rd     = ~nRD;
  assign wr     = ~nWR;
  assign m1     = ~nM1;
  assign rfsh   = ~nRFSH;
  assign strobe = mreq | iorq;
  assign bad    = (rd & wr) | (mreq & iorq);
  // Reset blocks the tick so an in-flight cycle can neither classify nor write.
  assign tick   = ce & ~reset;

  always_comb begin
    cls = 3'd0;
    if (mreq) begin
      if (rfsh)          cls = CLS_RFSH;
      else if (m1 && rd) cls = CLS_FETCH;
      else if (rd)       cls = CLS_MRD;
      else if (wr)       cls = CLS_MWR;
    end else if (iorq) begin
      if (m1)            cls = CLS_INTA;
      else if (rd)       cls = CLS_IORD;
      else if (wr)       cls = CLS_IOWR;
    end
  end

  always_comb begin
    state_d  = state_q;
    classify = 1'b0;
    err_hit  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SYNC:   if (!strobe) state_d = ST_IDLE;
        ST_IDLE, ST_WAIT_QUAL: begin
          if (!strobe) begin
            state_d = ST_IDLE;
          end else if (bad) begin
            // Park in SYNC so an illegal combination pulses cyc_err only once.
            err_hit = 1'b1;
            state_d = ST_SYNC;
          end else if (cls != 3'd0) begin
            classify = 1'b1;
            state_d  = ST_ACTIVE;
          end else begin
            state_d = ST_WAIT_QUAL;
          end
        end
        ST_ACTIVE: if (!strobe) state_d = ST_IDLE;
        default:   state_d = ST_SYNC;
      endcase
    end
  end

  always_comb begin
    rd_data = din_q;
    case (cls)
      CLS_FETCH, CLS_MRD: rd_data = (cpu_addr[15:14] == 2'b00) ? cpu_addr[7:0] : ram_q[cpu_addr[7:0]];
      CLS_IORD:           rd_data = cpu_addr[0] ? 8'hFF : 8'hBF;
      CLS_INTA:           rd_data = 8'hFF;
      default:            rd_data = din_q;
    endcase
  end

  assign din_d   = classify ? rd_data : din_q;
  assign ram_we  = classify && (cls == CLS_MWR) && (cpu_addr[15:14] != 2'b00);
  assign port_we = classify && (cls == CLS_IOWR) && !cpu_addr[0];
  assign cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_SYNC;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      type_q  <= 3'd0;
      addr_q  <= 16'd0;
      din_q   <= 8'hFF;
      fe_q    <= 8'h00;
      cnt_q   <= CNT_LAST;
      nint_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      vld_q   <= classify;
      err_q   <= err_hit;
      din_q   <= din_d;
      if (classify) begin
        type_q <= cls;
        addr_q <= cpu_addr;
      end
      if (port_we) fe_q <= cpu_dout;
      if (ce) begin
        cnt_q  <= cnt_d;
        nint_q <= !(cnt_d < INT_THR);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (ram_we) ram_q[cpu_addr[7:0]] <= cpu_dout;
  end

  assign cpu_din   = din_q;
  assign nINT      = nint_q;
  assign cyc_valid = vld_q;
  assign cyc_type  = type_q;
  assign cyc_addr  = addr_q;
  assign cyc_err   = err_q;
  assign port_fe   = fe_q;

`ifdef CONTENTION_EN
  logic        cont_hit;
  logic        cont_q;
  logic [15:0] cont_cnt_q;

  assign cont_hit = classify &&
                    ((((cls == CLS_FETCH) || (cls == CLS_MRD) || (cls == CLS_MWR)) && (cpu_addr[15:14] == 2'b01)) ||
                     (((cls == CLS_IORD) || (cls == CLS_IOWR)) && !cpu_addr[0]));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cont_q     <= 1'b0;
      cont_cnt_q <= 16'd0;
    end else begin
      cont_q <= cont_hit;
      if (cont_hit) cont_cnt_q <= cont_cnt_q + 16'd1;
    end
  end

  assign contended = cont_q;
  assign cont_cnt  = cont_cnt_q;
`else
  assign contended = 1'b0;
  assign cont_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder with a short frame (FRAME_LEN=100, INT_LEN=4).
module tb_z80_bus_responder;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        nMREQ, nIORQ, nRD, nWR, nM1, nRFSH;
  logic [7:0]  cpu_din;
  logic        nINT;
  logic        cyc_valid;
  logic [2:0]  cyc_type;
  logic [15:0] cyc_addr;
  logic        cyc_err;
  logic [7:0]  port_fe;
  logic        contended;
  logic [15:0] cont_cnt;

  int n_vec = 0;
  int n_err = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  z80_bus_responder #(.FRAME_LEN(100), .INT_LEN(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH),
    .cpu_din(cpu_din), .nINT(nINT), .cyc_valid(cyc_valid), .cyc_type(cyc_type),
    .cyc_addr(cyc_addr), .cyc_err(cyc_err), .port_fe(port_fe),
    .contended(contended), .cont_cnt(cont_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (cyc_valid === 1'b1) vld_cnt++;
    if (cyc_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic bus(input logic m, input logic i, input logic r, input logic w,
                     input logic f, input logic rf, input logic [15:0] a, input logic [7:0] d);
    nMREQ = m; nIORQ = i; nRD = r; nWR = w; nM1 = f; nRFSH = rf;
    cpu_addr = a; cpu_dout = d;
  endtask

  task automatic release_bus();
    bus(1, 1, 1, 1, 1, 1, cpu_addr, cpu_dout);
    step();
  endtask

  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    bus(1, 1, 1, 1, 1, 1, 16'h0000, 8'h00);
    repeat (3) step();

    chk("rst cpu_din", 32'(cpu_din), 32'hFF);
    chk("rst nINT", 32'(nINT), 32'h1);
    chk("rst cyc_valid", 32'(cyc_valid), 32'h0);
    chk("rst cyc_type", 32'(cyc_type), 32'h0);
    chk("rst cyc_addr", 32'(cyc_addr), 32'h0);
    chk("rst cyc_err", 32'(cyc_err), 32'h0);
    chk("rst port_fe", 32'(port_fe), 32'h0);
    chk("rst contended", 32'(contended), 32'h0);
    chk("rst cont_cnt", 32'(cont_cnt), 32'h0);

    // Frame: counter restarts at 0 on the first tick, nINT low while count < 4.
    reset = 1'b0;
    for (int k = 1; k <= 205; k++) begin
      step();
      chk($sformatf("nINT tick %0d", k), 32'(nINT), (((k - 1) % 100) < 4) ? 32'h0 : 32'h1);
    end

    // Opcode fetch from ROM area.
    bus(0, 1, 0, 1, 0, 1, 16'h0012, 8'h00); step();
    chk("fetch valid", 32'(cyc_valid), 32'h1);
    chk("fetch type", 32'(cyc_type), 32'h1);
    chk("fetch addr", 32'(cyc_addr), 32'h0012);
    chk("fetch din", 32'(cpu_din), 32'h12);
    step();
    chk("fetch pulse end", 32'(cyc_valid), 32'h0);
    chk("fetch type hold", 32'(cyc_type), 32'h1);
    release_bus();
    chk("fetch one valid", 32'(vld_cnt), 32'd1);

    // RAM write with late nWR, then read back through a mirror address.
    bus(0, 1, 1, 1, 1, 1, 16'h6034, 8'hA5); step();
    chk("wq no valid", 32'(cyc_valid), 32'h0);
    bus(0, 1, 1, 0, 1, 1, 16'h6034, 8'hA5); step();
    chk("wr valid", 32'(cyc_valid), 32'h1);
    chk("wr type", 32'(cyc_type), 32'h3);
    chk("wr addr", 32'(cyc_addr), 32'h6034);
`ifdef CONTENTION_EN
    chk("wr contended", 32'(contended), 32'h1);
    chk("wr cont_cnt", 32'(cont_cnt), 32'h1);
`else
    chk("wr contended", 32'(contended), 32'h0);
    chk("wr cont_cnt", 32'(cont_cnt), 32'h0);
`endif
    release_bus();
    bus(0, 1, 0, 1, 1, 1, 16'hC034, 8'h00); step();
    chk("rd type", 32'(cyc_type), 32'h2);
    chk("rd din", 32'(cpu_din), 32'hA5);
    release_bus();

    bus(0, 1, 0, 1, 1, 1, 16'h0034, 8'h00); step();
    chk("rom din", 32'(cpu_din), 32'h34);
    release_bus();

    // Write below 0x4000 is dropped; RAM[0x34] keeps 0xA5.
    bus(0, 1, 1, 0, 1, 1, 16'h2034, 8'h5A); step();
    chk("romwr type", 32'(cyc_type), 32'h3);
    release_bus();
    bus(0, 1, 0, 1, 1, 1, 16'h4034, 8'h00); step();
    chk("romwr ignored", 32'(cpu_din), 32'hA5);
    release_bus();

    // IO writes and reads.
    bus(1, 0, 1, 0, 1, 1, 16'h00FE, 8'h07); step();
    chk("iowr type", 32'(cyc_type), 32'h5);
    chk("iowr port_fe", 32'(port_fe), 32'h07);
    release_bus();
    bus(1, 0, 1, 0, 1, 1, 16'h00FF, 8'h33); step();
    chk("iowr odd port_fe", 32'(port_fe), 32'h07);
    release_bus();
    bus(1, 0, 0, 1, 1, 1, 16'h00FE, 8'h00); step();
    chk("iord even type", 32'(cyc_type), 32'h4);
    chk("iord even din", 32'(cpu_din), 32'hBF);
    release_bus();
    bus(1, 0, 0, 1, 1, 1, 16'h00FF, 8'h00); step();
    chk("iord odd din", 32'(cpu_din), 32'hFF);
    release_bus();
    bus(1, 0, 0, 1, 1, 1, 16'h00FE, 8'h00); step();
    chk("iord even din2", 32'(cpu_din), 32'hBF);
    release_bus();

    bus(1, 0, 1, 1, 0, 1, 16'h0000, 8'h00); step();
    chk("inta type", 32'(cyc_type), 32'h7);
    chk("inta din", 32'(cpu_din), 32'hFF);
    release_bus();

    bus(0, 1, 0, 1, 1, 1, 16'h0056, 8'h00); step();
    chk("rom56 din", 32'(cpu_din), 32'h56);
    release_bus();

    // Refresh outranks read and does not load cpu_din.
    bus(0, 1, 0, 1, 1, 0, 16'h0080, 8'h00); step();
    chk("rfsh type", 32'(cyc_type), 32'h6);
    chk("rfsh din hold", 32'(cpu_din), 32'h56);
    release_bus();

    // Class change within ACTIVE is not a new cycle.
    bus(0, 1, 0, 1, 1, 1, 16'h0001, 8'h00); step();
    chk("cc type", 32'(cyc_type), 32'h2);
    chk("cc din", 32'(cpu_din), 32'h01);
    bus(0, 1, 1, 0, 1, 1, 16'h0001, 8'h00); step();
    chk("cc no valid", 32'(cyc_valid), 32'h0);
    chk("cc type hold", 32'(cyc_type), 32'h2);
    release_bus();

    // Illegal strobe combinations.
    bus(0, 1, 1, 0, 1, 1, 16'h4055, 8'h3C); step();
    release_bus();
    bus(0, 1, 0, 0, 1, 1, 16'h4055, 8'hEE); step();
    chk("err rdwr pulse", 32'(cyc_err), 32'h1);
    chk("err rdwr no valid", 32'(cyc_valid), 32'h0);
    step();
    chk("err pulse end", 32'(cyc_err), 32'h0);
    release_bus();
    bus(0, 1, 0, 1, 1, 1, 16'h4055, 8'h00); step();
    chk("err ram unchanged", 32'(cpu_din), 32'h3C);
    release_bus();
    bus(0, 0, 0, 1, 1, 1, 16'h0000, 8'h00); step();
    chk("err mreq iorq", 32'(cyc_err), 32'h1);
    chk("err mreq iorq no valid", 32'(cyc_valid), 32'h0);
    release_bus();

    // ce low freezes the FSM.
    ce = 1'b0;
    bus(0, 1, 0, 1, 1, 1, 16'h0010, 8'h00); step(); step();
    chk("ce low no valid", 32'(cyc_valid), 32'h0);
    ce = 1'b1;
    step();
    chk("ce high valid", 32'(cyc_valid), 32'h1);
    chk("ce high din", 32'(cpu_din), 32'h10);
    release_bus();

    // Reset during an active read: no classification until strobes release.
    reset = 1'b1;
    bus(0, 1, 0, 1, 1, 1, 16'h0042, 8'h00); step();
    chk("mid rst valid", 32'(cyc_valid), 32'h0);
    chk("mid rst type", 32'(cyc_type), 32'h0);
    chk("mid rst din", 32'(cpu_din), 32'hFF);
    chk("mid rst port_fe", 32'(port_fe), 32'h0);
    reset = 1'b0;
    step(); step();
    chk("post rst no valid", 32'(cyc_valid), 32'h0);
    chk("post rst din", 32'(cpu_din), 32'hFF);
    release_bus();
    bus(0, 1, 0, 1, 1, 1, 16'h0042, 8'h00); step();
    chk("reassert valid", 32'(cyc_valid), 32'h1);
    chk("reassert din", 32'(cpu_din), 32'h42);
    release_bus();

    chk("total valids", 32'(vld_cnt), 32'd19);
    chk("total errs", 32'(err_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 Parameter FRAME_LEN, default 69888, gives the frame length in ce ticks.
REQ-002 Parameter INT_LEN, default 32, gives the nINT low width in ce ticks; it SHALL be less than FRAME_LEN.
REQ-003 clk_sys  in  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ce  in  1  sample enable; state SHALL advance only on clk_sys edges with ce=1.
REQ-006 cpu_addr  in  16  Z80 address bus.
REQ-007 cpu_dout  in  8  data written by the CPU.
REQ-008 nMREQ, nIORQ, nRD, nWR, nM1, nRFSH  in  1 each  active-low Z80 strobes.
REQ-009 cpu_din  out  8  registered read data returned to the CPU.
REQ-010 nINT  out  1  frame interrupt, active low.
REQ-011 cyc_valid  out  1  one-clock pulse when a bus cycle is classified.
REQ-012 cyc_type  out  3  cycle class: 1 fetch, 2 mem read, 3 mem write, 4 IO read, 5 IO write, 6 refresh, 7 int ack.
REQ-013 cyc_addr  out  16  address captured at classification.
REQ-014 cyc_err  out  1  one-clock pulse on an illegal strobe combination.
REQ-015 port_fe  out  8  last value written to an even IO port.
REQ-016 contended  out  1, cont_cnt  out  16  contention outputs (see Configuration).

Function
REQ-017 FSM states are SYNC, IDLE, WAIT_QUAL and ACTIVE; all transitions SHALL occur on ce ticks.
REQ-018 SYNC SHALL go to IDLE on the first tick with nMREQ=1 and nIORQ=1.
REQ-019 IDLE SHALL go to WAIT_QUAL when nMREQ=0 or nIORQ=0 and no qualifier (nRD, nWR, nRFSH, nM1 with IORQ) is low.
REQ-020 IDLE or WAIT_QUAL SHALL go to ACTIVE on the first tick where strobe and qualifier are both present.
REQ-021 Classification priority SHALL be: MREQ+RFSH=6, MREQ+M1+RD=1, MREQ+RD=2, MREQ+WR=3, IORQ+M1=7, IORQ+RD=4, IORQ+WR=5.
REQ-022 ACTIVE SHALL go to IDLE on the tick where nMREQ=1 and nIORQ=1; a class change inside ACTIVE SHALL NOT create a new cycle.
REQ-023 A strobe release in WAIT_QUAL SHALL return to IDLE with no cyc_valid.
REQ-024 cyc_valid, cyc_type and cyc_addr SHALL update on the clk_sys edge after the classifying tick (latency 1 clk_sys); cyc_type and cyc_addr SHALL then hold.
REQ-025 Read data for classes 1 and 2 SHALL be cpu_addr[7:0] for addresses 0x0000-0x3FFF, otherwise RAM[cpu_addr[7:0]] (256x8).
REQ-026 Read data for class 4 SHALL be 8'hBF when cpu_addr[0]=0 and 8'hFF when cpu_addr[0]=1.
REQ-027 Read data for class 7 SHALL be 8'hFF.
REQ-028 cpu_din SHALL be loaded with the same latency as cyc_valid and SHALL hold otherwise.
REQ-029 Class 3 with address >= 0x4000 SHALL write cpu_dout to RAM[addr[7:0]]; writes below 0x4000 SHALL be ignored.
REQ-030 Class 5 with cpu_addr[0]=0 SHALL load cpu_dout into port_fe.
REQ-031 A read of a RAM location written in the immediately preceding cycle SHALL return the new data.
REQ-032 cyc_err SHALL pulse when nRD=0 and nWR=0 together, or when nMREQ=0 and nIORQ=0 together; that cycle SHALL NOT be classified and no write SHALL occur.
REQ-033 The frame counter SHALL count 0..FRAME_LEN-1 and wrap to 0.
REQ-034 nINT SHALL be 0 while the frame counter is below INT_LEN, independent of int-ack.

Reset
REQ-035 On reset, the FSM SHALL enter SYNC and outputs SHALL reset to: cpu_din=8'hFF, nINT=1, cyc_valid=0, cyc_type=0, cyc_addr=0, cyc_err=0, port_fe=0, contended=0, cont_cnt=0.
REQ-036 On reset, the frame counter SHALL reset to FRAME_LEN-1, so nINT first falls on the first tick after reset.
REQ-037 RAM contents SHALL be undefined after reset.
REQ-038 Reset asserted mid-cycle SHALL abort the cycle with no write; a strobe still low after reset release SHALL NOT be classified.

Configuration
REQ-039 With CONTENTION_EN defined, contended SHALL pulse with cyc_valid for classes 1-3 at 0x4000-0x7FFF and class 4/5 with A0=0, and cont_cnt SHALL increment on each such pulse, wrapping at 0xFFFF.
REQ-040 Without CONTENTION_EN, contended and cont_cnt SHALL be held at 0 and the related logic SHALL be omitted.

Verification
REQ-041 Fetch at 0x0012 (nMREQ, nRD, nM1 low together) -> cyc_type=1, cpu_din=8'h12, one cyc_valid.
REQ-042 Write 8'hA5 to 0x6034 (nMREQ low, then nWR one tick later), then read 0xC034 -> WAIT_QUAL seen, then classes 3 and 2, cpu_din=8'hA5; with CONTENTION_EN, cont_cnt=1.
REQ-043 IO write 8'h07 to 0x00FE, then IO read 0x00FE and 0x00FF -> port_fe=8'h07, cpu_din 8'hBF then 8'hFF.
REQ-044 FRAME_LEN=100, INT_LEN=4, continuous ce -> nINT low for 4 ticks every 100 ticks, starting on the first tick after reset.
REQ-045 nRD and nWR low together during nMREQ=0 -> cyc_err pulse, no cyc_valid, RAM unchanged.
REQ-046 Reset asserted while nMREQ and nRD are low -> no classification until both strobes go high and then re-assert.
